load_store_unit: RTL and testbench

//  Sits between the execute stage and the word-wide synchronous data memory. Turns RV32I loads/stores
//  (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses, runs read-modify-write for sub-word stores
//  (the memory has no byte enables), and returns sign/zero-extended load data. Flags misaligned or

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`timescale 1ns / 1ps
// Load/store unit: turns RV32I byte/half/word loads and stores into accesses to a word-wide
// synchronous memory without byte enables. Sub-word stores use read-modify-write; loads are
// sign/zero-extended. Misaligned or illegal requests are answered with resp_err and never
// touch memory.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,  // only 32 is supported
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StLoad, StMerge} state_e;

  state_e                state_q, state_d;
  logic                  accept;
  logic                  req_err;
  logic                  mem_we_raw;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [15:0]           wdata_q;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_ext;
  logic [31:0]           merged;

  // Byte-address bits above the memory's reach are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_wdata[DATA_WIDTH-1:16]};

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // A write must never escape while reset is held, even combinationally.
  assign mem_we = mem_we_raw && !rst;

  // Alignment and funct3 legality of the incoming request.
  always_comb begin
    req_err = 1'b1;
    case (req_funct3)
      3'd0:    req_err = 1'b0;
      3'd1:    req_err = req_addr[0];
      3'd2:    req_err = |req_addr[1:0];
      3'd4:    req_err = req_we;
      3'd5:    req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Lane selection and extension of the returned word for loads.
  always_comb begin
    byte_sel = mem_rd[7:0];
    case (off_q)
      2'd0: byte_sel = mem_rd[7:0];
      2'd1: byte_sel = mem_rd[15:8];
      2'd2: byte_sel = mem_rd[23:16];
      2'd3: byte_sel = mem_rd[31:24];
      default: byte_sel = mem_rd[7:0];
    endcase
    half_sel = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'h0, byte_sel};
      3'd5:    load_ext = {16'h0, half_sel};
      default: load_ext = mem_rd;
    endcase
  end

  // Read-modify-write: replace the addressed byte or half of the old word.
  always_comb begin
    merged = mem_rd;
    if (funct3_q[1:0] == 2'd0) begin
      case (off_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rd;
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next state, memory interface and response generation.
  always_comb begin
    state_d      = state_q;
    mem_a        = waddr_q;
    mem_we_raw   = 1'b0;
    mem_wd       = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        mem_a = req_addr[ADDR_WIDTH+1:2];
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3 == 3'd2) begin
            mem_we_raw   = 1'b1;
            mem_wd       = req_wdata;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end else begin
            state_d = StMerge;
          end
        end
      end
      StLoad: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_ext;
        state_d      = StIdle;
      end
      StMerge: begin
        mem_we_raw   = 1'b1;
        mem_wd       = merged;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q <= '0;
      off_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      funct3_q <= req_funct3;
      off_q    <= req_addr[1:0];
      waddr_q  <= req_addr[ADDR_WIDTH+1:2];
      wdata_q  <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns / 1ps
// Directed bench for load_store_unit with a word-wide synchronous memory model.
module tb_load_store_unit;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Synchronous memory: registered read, write on enable.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    mem_rd <= mem[mem_a];
  end

  always @(posedge clk) if (mem_we === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
    end
  endtask

  // One request from an idle cycle; waits (bounded) for its response and checks it.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err, input logic exp_we0);
    int lat;
    @(negedge clk);
    chk(tag, "ready", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    chk(tag, "we0", {31'h0, mem_we}, {31'h0, exp_we0});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, "lat", lat, exp_lat);
    chk(tag, "rdata", resp_rdata, exp_rdata);
    chk(tag, "err", {31'h0, resp_err}, {31'h0, exp_err});
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset", "valid", {31'h0, resp_valid}, 32'd0);
    chk("reset", "rdata", resp_rdata, 32'h0);
    chk("reset", "err", {31'h0, resp_err}, 32'd0);
    chk("reset", "we", {31'h0, mem_we}, 32'd0);
    chk("reset", "ready", {31'h0, req_ready}, 32'd1);
    rst = 1'b0;

    // Reset asserted during the merge cycle of an SB
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_merge", "busy", {31'h0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_merge", "we", {31'h0, mem_we}, 32'd0);
    chk("rst_merge", "idle", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_merge", "valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_merge", "rdata", resp_rdata, 32'h0);
    @(negedge clk);
    chk("rst_merge", "valid2", {31'h0, resp_valid}, 32'd0);
    chk("rst_merge", "ready", {31'h0, req_ready}, 32'd1);
    chk("rst_merge", "writes", wr_cnt, 32'd0);

    // Word store/load and response pulse/hold
    xact("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 1'b1);
    xact("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    chk("lw10", "pulse", {31'h0, resp_valid}, 32'd0);
    chk("lw10", "hold", resp_rdata, 32'hDEADBEEF);
    xact("sw14", 1'b1, 3'd2, 32'h14, 32'h0BADF00D, 1, 32'h0, 1'b0, 1'b1);

    // Byte store and byte loads
    xact("sb13", 1'b1, 3'd0, 32'h13, 32'h000000A5, 2, 32'h0, 1'b0, 1'b0);
    xact("lw_sb", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'hA5ADBEEF, 1'b0, 1'b0);
    xact("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 2, 32'hFFFFFFA5, 1'b0, 1'b0);
    xact("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 2, 32'h000000A5, 1'b0, 1'b0);

    // Half store and half loads
    xact("sh12", 1'b1, 3'd1, 32'h12, 32'h00001234, 2, 32'h0, 1'b0, 1'b0);
    xact("lw_sh", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'h1234BEEF, 1'b0, 1'b0);
    xact("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 2, 32'h00001234, 1'b0, 1'b0);
    xact("lh10", 1'b0, 3'd1, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 1'b0);
    // Address bits above the memory are ignored
    xact("lw_hi", 1'b0, 3'd2, 32'h1010, 32'h0, 2, 32'h1234BEEF, 1'b0, 1'b0);

    // Errors: no write, one-cycle latency, zero data
    snap = wr_cnt;
    xact("lw11", 1'b0, 3'd2, 32'h11, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    xact("sh13", 1'b1, 3'd1, 32'h13, 32'h0000FFFF, 1, 32'h0, 1'b1, 1'b0);
    xact("f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    xact("sbu", 1'b1, 3'd4, 32'h10, 32'h000000FF, 1, 32'h0, 1'b1, 1'b0);
    xact("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    chk("err", "writes", wr_cnt, snap);
    xact("lw_err", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'h1234BEEF, 1'b0, 1'b0);

    // Back-to-back loads with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    chk("b2b", "busy", {31'h0, req_ready}, 32'd0);
    chk("b2b", "v1_early", {31'h0, resp_valid}, 32'd0);
    req_addr = 32'h14;
    @(negedge clk);
    chk("b2b", "v1", {31'h0, resp_valid}, 32'd1);
    chk("b2b", "d1", resp_rdata, 32'h1234BEEF);
    chk("b2b", "ready1", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b", "gap", {31'h0, resp_valid}, 32'd0);
    chk("b2b", "taken", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b", "v2", {31'h0, resp_valid}, 32'd1);
    chk("b2b", "d2", resp_rdata, 32'h0BADF00D);
    chk("b2b", "e2", {31'h0, resp_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
